fifo_wr_arbiter: RTL and testbench

// - Round-robin arbiter sharing the single write port of asynchfifo among NUM_REQ producers.
// - Lives in the wr_clk domain, directly in front of the FIFO's wr_en/wdata/full pins.
// - Grants only while the FIFO is not full, so the FIFO overflow flag must never assert.
// - Keeps saturating write and stall statistics for the environment/scoreboard.

---
 rtl/fifo_wr_arbiter_if.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
// Purpose: bundles the producer handshake and the FIFO write-port signals that
//          sit between NUM_REQ producers, the fifo_wr_arbiter and asynchfifo.
// Signals:
//   req_valid  NUM_REQ             producer i has a word to write
//   req_data   NUM_REQ*DATA_WIDTH  packed, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  NUM_REQ             one-hot (or zero) grant from the arbiter
//   full       1                   FIFO full flag
//   wr_en      1                   FIFO write enable
//   wdata      DATA_WIDTH          FIFO write data
// Modports:
//   master  environment side (producers + FIFO), drives req_valid/req_data/full
//   slave   arbiter side, drives req_ready/wr_en/wdata
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wdata;

  modport master (
    output req_valid, req_data, full,
    input  req_ready, wr_en, wdata
  );

  modport slave (
    input  req_valid, req_data, full,
    output req_ready, wr_en, wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Purpose: round-robin arbiter sharing the single write port of asynchfifo
//          among NUM_REQ producers, in the wr_clk domain. Grants only while the
//          FIFO is not full, and keeps saturating write/stall statistics.
// Ports:
//   wr_clk     in   write-domain clock, all logic on posedge
//   res        in   synchronous active-high reset
//   bus        slave modport of fifo_wr_arbiter_if (handshake + FIFO write port)
//   grant_id   out  index of the last requester that transferred (registered)
//   wr_cnt     out  total beats written, saturating
//   stall_cnt  out  cycles with any req_valid while full, saturating
// Build option: define FIFO_ARB_BURST_EN to let a winner keep the port for up
//   to BURST_LEN consecutive beats; undefined gives per-beat round-robin.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | round-robin search from rr_ptr (only state without burst option)
// ST_LOCK | port owned by lock_id until BURST_LEN beats or lock_id drops valid
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int BURST_LEN  = 4,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                 wr_clk,
  input  logic                 res,
  fifo_wr_arbiter_if.slave     bus,
  output logic [IDW-1:0]       grant_id,
  output logic [CNT_WIDTH-1:0] wr_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                  win_found;
  logic [IDW-1:0]        win_idx;
  logic [NUM_REQ-1:0]    ready_c;
  logic                  wr_en_c;
  logic [DATA_WIDTH-1:0] wdata_c;

`ifdef FIFO_ARB_BURST_EN
  localparam int BCW = $clog2(BURST_LEN + 1);
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
`endif

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] k);
    return (k == IDW'(NUM_REQ - 1)) ? '0 : k + IDW'(1);
  endfunction

  // Winner search: indices at or above rr_ptr first, then the wrapped-around
  // ones below it, which gives the rr_ptr, rr_ptr+1, ... mod NUM_REQ order
  // without modulo arithmetic (NUM_REQ need not be a power of two).
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    if (state_q == ST_IDLE) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && bus.req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
          win_found = 1'b1;
          win_idx   = IDW'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && bus.req_valid[i] && (IDW'(i) < rr_ptr_q)) begin
          win_found = 1'b1;
          win_idx   = IDW'(i);
        end
      end
    end
`ifdef FIFO_ARB_BURST_EN
    else begin
      win_found = bus.req_valid[lock_id_q];
      win_idx   = lock_id_q;
    end
`endif
  end

  // Grant is suppressed while full or in reset, so a write can never land on
  // a full FIFO and nothing leaks out during reset.
  always_comb begin
    ready_c = '0;
    wdata_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_found && !bus.full && !res && (win_idx == IDW'(i))) begin
        ready_c[i] = 1'b1;
        wdata_c    = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign wr_en_c       = |(bus.req_valid & ready_c);
  assign bus.req_ready = ready_c;
  assign bus.wr_en     = wr_en_c;
  assign bus.wdata     = wdata_c;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
`ifdef FIFO_ARB_BURST_EN
    lock_id_d  = lock_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_en_c) begin
          if (BURST_LEN <= 1) begin
            rr_ptr_d = next_id(win_idx);
          end else begin
            state_d    = ST_LOCK;
            lock_id_d  = win_idx;
            beat_cnt_d = BCW'(1);
          end
        end
      end
      ST_LOCK: begin
        // Owner gone: release even if full, otherwise the port would stall.
        if (!bus.req_valid[lock_id_q]) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = next_id(lock_id_q);
          beat_cnt_d = '0;
        end else if (wr_en_c) begin
          if (beat_cnt_q == BCW'(BURST_LEN - 1)) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = next_id(lock_id_q);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
`else
    state_d = ST_IDLE;
    if (wr_en_c) begin
      rr_ptr_d = next_id(win_idx);
    end
`endif
  end

  always_ff @(posedge wr_clk) begin
    if (res) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_id  <= '0;
      wr_cnt    <= '0;
      stall_cnt <= '0;
`ifdef FIFO_ARB_BURST_EN
      lock_id_q  <= '0;
      beat_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef FIFO_ARB_BURST_EN
      lock_id_q  <= lock_id_d;
      beat_cnt_q <= beat_cnt_d;
`endif
      if (wr_en_c) begin
        grant_id <= win_idx;
      end
      if (wr_en_c && (wr_cnt != '1)) begin
        wr_cnt <= wr_cnt + CNT_WIDTH'(1);
      end
      if ((|bus.req_valid) && bus.full && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Purpose: self-checking bench for fifo_wr_arbiter. Directed scenarios
//          (reset, fairness, backpressure, wrap, burst release, saturation)
//          followed by randomized producers and a randomly draining FIFO,
//          all checked every cycle against a behavioural model. A second
//          instance with CNT_WIDTH=4 shares the stimulus to check saturation.
// Honours FIFO_ARB_BURST_EN the same way as the design.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BL    = 4;
  localparam int DEPTH = 5;

  logic wr_clk = 1'b0;
  logic res;
  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus_s ();

  logic [1:0]  grant_id, grant_id_s;
  logic [15:0] wr_cnt, stall_cnt;
  logic [3:0]  wr_cnt_s, stall_cnt_s;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(16), .BURST_LEN(BL)) dut (
    .wr_clk(wr_clk), .res(res), .bus(bus.slave),
    .grant_id(grant_id), .wr_cnt(wr_cnt), .stall_cnt(stall_cnt)
  );

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(4), .BURST_LEN(BL)) dut_s (
    .wr_clk(wr_clk), .res(res), .bus(bus_s.slave),
    .grant_id(grant_id_s), .wr_cnt(wr_cnt_s), .stall_cnt(stall_cnt_s)
  );

  assign bus_s.req_valid = bus.req_valid;
  assign bus_s.req_data  = bus.req_data;
  assign bus_s.full      = bus.full;

  int n_total, n_bad;
  int m_ptr, m_lock, m_beats, m_id, m_wr, m_stall, last_k;
  int occ;
  logic force_full, fifo_auto;
  int glog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Which producer should win right now, from the arbitration rules.
  function automatic int model_winner();
    if (res || bus.full) return -1;
    if (m_lock >= 0) return bus.req_valid[m_lock] ? m_lock : -1;
    for (int j = 0; j < N; j++) begin
      int k = (m_ptr + j) % N;
      if (bus.req_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic upd_full();
    bus.full = force_full | (fifo_auto && (occ >= DEPTH));
  endtask

  task automatic tick();
    int k;
    logic [N-1:0]  exp_r;
    logic [DW-1:0] exp_d;
    @(negedge wr_clk);
    k     = model_winner();
    exp_r = '0;
    exp_d = '0;
    if (k >= 0) begin
      exp_r[k] = 1'b1;
      exp_d    = bus.req_data[k*DW +: DW];
    end
    chk("req_ready", bus.req_ready, exp_r);
    chk("wr_en", bus.wr_en, (k >= 0));
    chk("wdata", bus.wdata, exp_d);
    chk("no_overflow", bus.wr_en & bus.full, 0);
    chk("req_ready_s", bus_s.req_ready, exp_r);
    glog.push_back(onehot_idx(bus.req_ready));
    @(posedge wr_clk);
    if (res) begin
      m_ptr = 0; m_id = 0; m_wr = 0; m_stall = 0; m_lock = -1; m_beats = 0;
    end else begin
      if ((|bus.req_valid) && bus.full) m_stall++;
      if (k >= 0) begin
        m_wr++;
        m_id = k;
`ifdef FIFO_ARB_BURST_EN
        if (m_lock < 0) begin
          if (BL > 1) begin m_lock = k; m_beats = 1; end
          else m_ptr = (k + 1) % N;
        end else begin
          m_beats++;
          if (m_beats == BL) begin m_ptr = (m_lock + 1) % N; m_lock = -1; m_beats = 0; end
        end
`else
        m_ptr = (k + 1) % N;
`endif
      end
`ifdef FIFO_ARB_BURST_EN
      else if (m_lock >= 0 && !bus.req_valid[m_lock]) begin
        m_ptr = (m_lock + 1) % N; m_lock = -1; m_beats = 0;
      end
`endif
    end
    if (fifo_auto) begin
      if (k >= 0 && occ < DEPTH) occ++;
      if (occ > 0 && $urandom_range(0, 1) == 1) occ--;
    end
    last_k = k;
    #1;
    chk("grant_id", grant_id, m_id);
    chk("wr_cnt", wr_cnt, sat(m_wr, 65535));
    chk("stall_cnt", stall_cnt, sat(m_stall, 65535));
    chk("grant_id_s", grant_id_s, m_id);
    chk("wr_cnt_s", wr_cnt_s, sat(m_wr, 15));
    chk("stall_cnt_s", stall_cnt_s, sat(m_stall, 15));
    upd_full();
  endtask

  initial begin
    int exp_fair[8];
    n_total = 0; n_bad = 0;
    m_ptr = 0; m_lock = -1; m_beats = 0; m_id = 0; m_wr = 0; m_stall = 0; last_k = -1;
    occ = 0; force_full = 1'b0; fifo_auto = 1'b0;

    // reset with all requesters asking
    res = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_data  = 32'h44332211;
    upd_full();
    tick(); tick();
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_grant_id", grant_id, 0);

    // fairness
    res = 1'b0;
    glog.delete();
    repeat (8) tick();
`ifdef FIFO_ARB_BURST_EN
    exp_fair = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_fair = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    for (int i = 0; i < 8; i++) chk($sformatf("fair_order_%0d", i), glog[i], exp_fair[i]);
    chk("fair_wr_cnt", wr_cnt, 8);

    // backpressure
    force_full = 1'b1;
    bus.req_valid = 4'b0110;
    upd_full();
    glog.delete();
    repeat (3) tick();
    chk("bp_stall_cnt", stall_cnt, 3);
    chk("bp_wr_cnt", wr_cnt, 8);
    for (int i = 0; i < 3; i++) chk($sformatf("bp_no_grant_%0d", i), glog[i], -1);
    force_full = 1'b0;
    upd_full();
    tick();
    bus.req_valid = 4'b0100;
    tick();
`ifndef FIFO_ARB_BURST_EN
    chk("bp_first", glog[3], 1);
    chk("bp_second", glog[4], 2);
`endif

    // wrap of rr_ptr past NUM_REQ-1
    glog.delete();
    bus.req_valid = 4'b0100;
    tick(); tick();
    bus.req_valid = 4'b0101;
    tick(); tick();
`ifndef FIFO_ARB_BURST_EN
    chk("wrap_0", glog[0], 2);
    chk("wrap_1", glog[1], 2);
    chk("wrap_2", glog[2], 0);
    chk("wrap_3", glog[3], 2);
`endif

    // reset in the middle of traffic, then fresh start from requester 0
    res = 1'b1;
    bus.req_valid = 4'hF;
    tick();
    res = 1'b0;
    glog.delete();
    tick(); tick();
    chk("post_rst_first", glog[0], 0);
`ifdef FIFO_ARB_BURST_EN
    // owner 0 drops valid after 2 beats -> lock released, 1 wins next
    bus.req_valid = 4'b1110;
    tick(); tick();
    chk("burst_hold", glog[1], 0);
    chk("burst_drop_gap", glog[2], -1);
    chk("burst_drop_next", glog[3], 1);
`endif

    // counter saturation on the narrow instance
    res = 1'b1;
    tick();
    res = 1'b0;
    bus.req_valid = 4'hF;
    repeat (20) tick();
    chk("sat_wr_cnt_s", wr_cnt_s, 15);
    chk("sat_wr_cnt", wr_cnt, 20);
    force_full = 1'b1;
    upd_full();
    repeat (20) tick();
    chk("sat_stall_cnt_s", stall_cnt_s, 15);
    chk("sat_stall_cnt", stall_cnt, 20);
    force_full = 1'b0;

    // random producers against a randomly draining FIFO
    fifo_auto = 1'b1;
    occ = 0;
    upd_full();
    for (int c = 0; c < 800; c++) begin
      res = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (last_k == i || !bus.req_valid[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            bus.req_valid[i] = 1'b1;
            bus.req_data[i*DW +: DW] = DW'($urandom);
          end else begin
            bus.req_valid[i] = 1'b0;
          end
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
